// File: rtl/pio_cond_pkg.sv
// Shared constants and helpers for the PIO input conditioner.
// Key-word field positions and counter width sizing live here.
package pio_cond_pkg;

   localparam int unsigned WORD_W           = 32;
   localparam int unsigned KEY_WORD_LVL_LSB = 0;
   localparam int unsigned KEY_WORD_CNT_LSB = 8;

   // Bits needed to hold 0 .. n-1.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pio_input_conditioner_debounce_cell.sv
// debounce_cell: 2-FF synchroniser plus stable-level debouncer for one pin.
// rise pulses for one cycle just before level leaves its rest (reset) value.
module debounce_cell
   import pio_cond_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter logic        RESET_LEVEL     = 1'b0
) (
   input  logic clk_clk,
   input  logic reset_reset_n,
   input  logic din,
   output logic level,
   output logic rise
);

   localparam int unsigned    CW   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  TERM = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta;
   logic          sync;
   logic [CW-1:0] cnt;
   logic          terminal;

   assign terminal = (sync != level) && (cnt == TERM);
   assign rise     = terminal && (sync != RESET_LEVEL);

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         meta  <= RESET_LEVEL;
         sync  <= RESET_LEVEL;
         level <= RESET_LEVEL;
         cnt   <= '0;
      end else begin
         meta <= din;
         sync <= meta;
         if (sync == level) begin
            cnt <= '0;
         end else if (terminal) begin
            level <= sync;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/pio_input_conditioner.sv
// Debounced KEY/SW producer packing pressed levels and wrapping press counters.
// Optional macro AUTOREPEAT_EN adds hold-driven auto-repeat of the press counters.
module pio_input_conditioner
   import pio_cond_pkg::*;
#(
   parameter int unsigned N_KEYS          = 4,
   parameter int unsigned N_SW            = 10,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 6,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic [N_KEYS-1:0]   key_pin_n,
   input  logic [N_SW-1:0]     sw_pin,
   output logic [WORD_W-1:0]   key_word,
   output logic [WORD_W-1:0]   sw_word
);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
       KEY_WORD_CNT_LSB + N_KEYS * CNT_W > WORD_W || N_KEYS > 8 || N_SW > WORD_W) begin : g_bad_cfg
      $error("pio_input_conditioner: invalid parameter set");
   end

   logic [N_KEYS-1:0] key_lvl_n;
   logic [N_KEYS-1:0] key_rise;
   logic [N_KEYS-1:0] pressed;
   logic [N_KEYS-1:0] rep;
   logic [N_SW-1:0]   sw_lvl;
   logic [N_SW-1:0]   sw_rise_unused;
   logic [CNT_W-1:0]  press_cnt [N_KEYS];
   logic [WORD_W-1:0] key_next;

   for (genvar k = 0; k < N_KEYS; k++) begin : g_key
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_cell (
         .clk_clk       (clk_clk),
         .reset_reset_n (reset_reset_n),
         .din           (key_pin_n[k]),
         .level         (key_lvl_n[k]),
         .rise          (key_rise[k])
      );
   end

   for (genvar s = 0; s < N_SW; s++) begin : g_sw
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_cell (
         .clk_clk       (clk_clk),
         .reset_reset_n (reset_reset_n),
         .din           (sw_pin[s]),
         .level         (sw_lvl[s]),
         .rise          (sw_rise_unused[s])
      );
   end

   assign pressed = ~key_lvl_n;

`ifdef AUTOREPEAT_EN
   localparam int unsigned HW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
   logic [HW-1:0] hold [N_KEYS];

   // Countdown loaded at acceptance; reaching zero while held fires one repeat and reloads.
   always_ff @(posedge clk_clk) begin
      for (int unsigned k = 0; k < N_KEYS; k++) begin
         if (!reset_reset_n || (!pressed[k] && !key_rise[k])) begin
            hold[k] <= '0;
         end else if (key_rise[k]) begin
            hold[k] <= HW'(REPEAT_DELAY - 1);
         end else if (hold[k] == '0) begin
            hold[k] <= HW'(REPEAT_PERIOD - 1);
         end else begin
            hold[k] <= hold[k] - HW'(1);
         end
      end
   end

   always_comb begin
      rep = '0;
      for (int unsigned k = 0; k < N_KEYS; k++) begin
         rep[k] = pressed[k] && (hold[k] == '0);
      end
   end
`else
   assign rep = '0;
`endif

   always_ff @(posedge clk_clk) begin
      for (int unsigned k = 0; k < N_KEYS; k++) begin
         if (!reset_reset_n) begin
            press_cnt[k] <= '0;
         end else if (key_rise[k] || rep[k]) begin
            press_cnt[k] <= press_cnt[k] + CNT_W'(1);
         end
      end
   end

   always_comb begin
      key_next = '0;
      key_next[KEY_WORD_LVL_LSB +: N_KEYS] = pressed;
      for (int unsigned k = 0; k < N_KEYS; k++) begin
         key_next[KEY_WORD_CNT_LSB + k * CNT_W +: CNT_W] = press_cnt[k];
      end
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         key_word <= '0;
         sw_word  <= '0;
      end else begin
         key_word <= key_next;
         sw_word  <= WORD_W'(sw_lvl);
      end
   end

endmodule

// File: tb/tb_pio_input_conditioner.sv
// Scoreboard bench for pio_input_conditioner: stimulus queues expected words per cycle,
// a negedge monitor pops and compares them. Build with +define+AUTOREPEAT_EN to cover auto-repeat.
module tb_pio_input_conditioner;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  keys = 4'hF;
   logic [9:0]  sw = '0;
   logic [31:0] key_word;
   logic [31:0] sw_word;

   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   typedef struct {
      int unsigned cyc;
      logic [31:0] k;
      logic [31:0] s;
   } exp_t;

   exp_t  q[$];
   string nq[$];

   logic [3:0]  m_lvl = '0;
   logic [5:0]  m_cnt [4] = '{default: '0};
   logic [31:0] m_sw = '0;

   pio_input_conditioner #(
      .N_KEYS          (4),
      .N_SW            (10),
      .DEBOUNCE_CYCLES (8),
      .CNT_W           (6),
      .REPEAT_DELAY    (20),
      .REPEAT_PERIOD   (6)
   ) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .key_pin_n     (keys),
      .sw_pin        (sw),
      .key_word      (key_word),
      .sw_word       (sw_word)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] kw();
      return {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0], 4'b0000, m_lvl};
   endfunction

   task automatic push(input int unsigned dly, input string nm);
      exp_t e;
      e.cyc = cyc + dly;
      e.k   = kw();
      e.s   = m_sw;
      q.push_back(e);
      nq.push_back(nm);
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         n_checks++;
         if (q[0].cyc < cyc) begin
            n_fail++;
            $display("FAIL %s: check missed at cycle %0d, scheduled for %0d", nq[0], cyc, q[0].cyc);
         end else if (key_word !== q[0].k || sw_word !== q[0].s) begin
            n_fail++;
            $display("FAIL %s @%0d: key_word=%h sw_word=%h, required key_word=%h sw_word=%h",
                     nq[0], cyc, key_word, sw_word, q[0].k, q[0].s);
         end
         void'(q.pop_front());
         void'(nq.pop_front());
      end
   end

   initial begin
      // 1: reset with idle pins, then 100 quiet cycles
      tick(1);
      push(1, "reset_state");
      tick(2);
      rst_n = 1'b1;
      for (int i = 0; i <= 10; i++) push(i * 10, "idle_hold");
      tick(101);

      // 2: clean press and release of key 0
      keys[0] = 1'b0;
      push(10, "k0_press_early");
      m_lvl[0] = 1'b1;
      m_cnt[0] = m_cnt[0] + 1;
      push(11, "k0_press");
      tick(20);
      keys[0] = 1'b1;
      push(10, "k0_rel_early");
      m_lvl[0] = 1'b0;
      push(11, "k0_rel");
      tick(20);

      // 3: key 1 bounces every 3 cycles, then settles pressed
      for (int i = 0; i < 14; i++) begin
         keys[1] = (i % 2 == 1);
         push(2, "k1_bounce");
         tick(3);
      end
      keys[1] = 1'b0;
      push(10, "k1_settle_early");
      m_lvl[1] = 1'b1;
      m_cnt[1] = m_cnt[1] + 1;
      push(11, "k1_settle");
      tick(15);
      keys[1] = 1'b1;
      m_lvl[1] = 1'b0;
      push(11, "k1_rel");
      tick(15);

      // 4: 64 presses of key 2 wrap its counter back to 0
      for (int i = 0; i < 64; i++) begin
         keys[2] = 1'b0;
         m_lvl[2] = 1'b1;
         m_cnt[2] = m_cnt[2] + 1;
         push(11, "k2_press");
         tick(12);
         keys[2] = 1'b1;
         m_lvl[2] = 1'b0;
         push(11, "k2_rel");
         tick(12);
      end
      push(0, "k2_wrapped");
      tick(2);

      // 5: switches accepted, reset mid-debounce of key 3, switches re-accepted
      sw = 10'h2A5;
      push(10, "sw_early");
      m_sw = 32'h2A5;
      push(11, "sw_accept");
      tick(15);
      keys[3] = 1'b0;
      tick(5);
      rst_n = 1'b0;
      m_lvl = '0;
      m_cnt = '{default: '0};
      m_sw = '0;
      push(1, "rst_mid");
      tick(1);
      keys[3] = 1'b1;
      tick(2);
      rst_n = 1'b1;
      push(10, "post_rst_early");
      m_sw = 32'h2A5;
      push(11, "post_rst_sw");
      tick(20);

      // 6: key 0 held 40 cycles past acceptance
      keys[0] = 1'b0;
      push(10, "hold_early");
      m_lvl[0] = 1'b1;
      m_cnt[0] = 6'd1;
      push(11, "hold_accept");
      push(30, "hold_pre_rep");
`ifdef AUTOREPEAT_EN
      m_cnt[0] = 6'd2;
`endif
      push(31, "hold_first_rep");
`ifdef AUTOREPEAT_EN
      m_cnt[0] = 6'd5;
`endif
      push(51, "hold_40");
      tick(55);

      for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d checks pending, required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
